// File: rtl/stream_mux_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_rr_if
// Brief    : N-channel valid/ready input bundle plus single output stream
// Revision : 1.0
// ============================================================================
interface stream_mux_rr_if #(
    parameter int BITS     = 8,
    parameter int CHANNELS = 4
);
    localparam int SEL_BITS = $clog2(CHANNELS);

    logic [CHANNELS-1:0]      in_valid;
    logic [CHANNELS-1:0]      in_ready;
    logic [CHANNELS*BITS-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [BITS-1:0]          out_data;
    logic [SEL_BITS-1:0]      out_select;

    // slave: the multiplexer; master: producers and the consumer
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_select
    );
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_select
    );
endinterface
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_rr
// Brief    : N:1 stream mux, round-robin or fixed-priority, one output register
// Revision : 1.0
// ============================================================================
module stream_mux_rr #(
    parameter int BITS           = 8,
    parameter int CHANNELS       = 4,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    input  wire logic          clear,
    stream_mux_rr_if.slave     bus
);
    localparam int SEL_BITS = $clog2(CHANNELS);

    logic                r_valid;
    logic [BITS-1:0]     r_data;
    logic [SEL_BITS-1:0] r_sel;
    logic [SEL_BITS-1:0] r_rr_ptr;

    logic                w_can_load;
    logic                w_any;
    logic                w_xfer;
    logic [SEL_BITS-1:0] w_grant;
    logic [CHANNELS-1:0] w_ready;
    int                  w_idx;

    assign w_can_load = !r_valid || bus.out_ready;

    // Descending scan so the smallest offset from the pointer wins
    always_comb begin
        w_grant = '0;
        w_any   = 1'b0;
        w_idx   = 0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= CHANNELS) w_idx = w_idx - CHANNELS;
            if (bus.in_valid[w_idx]) begin
                w_grant = SEL_BITS'(w_idx);
                w_any   = 1'b1;
            end
        end
    end

    // Nothing is accepted while reset is asserted, even with valid inputs
    assign w_xfer = reset_n && w_can_load && !clear && w_any;

    always_comb begin
        w_ready = '0;
        if (w_xfer) w_ready[w_grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
        end else if (clear) begin
            r_valid <= 1'b0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= bus.in_data[int'(w_grant)*BITS +: BITS];
            r_sel   <= w_grant;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    generate
        if (FIXED_PRIORITY) begin : g_fixed
            assign r_rr_ptr = '0;
        end else begin : g_rr
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_rr_ptr <= '0;
                end else if (clear) begin
                    r_rr_ptr <= '0;
                end else if (w_xfer) begin
                    r_rr_ptr <= (w_grant == SEL_BITS'(CHANNELS - 1)) ? '0 : w_grant + 1'b1;
                end
            end
        end
    endgenerate

    assign bus.in_ready   = w_ready;
    assign bus.out_valid  = r_valid;
    assign bus.out_data   = r_data;
    assign bus.out_select = r_sel;
endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_mux_rr
// Brief    : Directed self-checking bench for round-robin and fixed-priority mux
// Revision : 1.0
// ============================================================================
module tb_stream_mux_rr;
    logic clk;
    logic reset_n;
    logic clear;
    int   n_checks;
    int   n_fail;

    stream_mux_rr_if #(.BITS(8), .CHANNELS(4)) br ();
    stream_mux_rr_if #(.BITS(8), .CHANNELS(4)) bf ();

    stream_mux_rr #(.BITS(8), .CHANNELS(4), .FIXED_PRIORITY(1'b0)) u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .bus     (br)
    );

    stream_mux_rr #(.BITS(8), .CHANNELS(4), .FIXED_PRIORITY(1'b1)) u_fp (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .bus     (bf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        clear    = 1'b0;
        br.in_valid  = 4'b1111;
        br.in_data   = {8'h03, 8'hA5, 8'h01, 8'h00};
        br.out_ready = 1'b1;
        bf.in_valid  = 4'b0000;
        bf.in_data   = {8'h23, 8'h22, 8'h21, 8'h20};
        bf.out_ready = 1'b1;

        // Reset with every channel requesting
        tick();
        tick();
        check("rst_in_ready",  32'(br.in_ready),   32'h0);
        check("rst_out_valid", 32'(br.out_valid),  32'h0);
        check("rst_out_data",  32'(br.out_data),   32'h0);
        check("rst_out_sel",   32'(br.out_select), 32'h0);

        // Single channel 2
        reset_n     = 1'b1;
        br.in_valid = 4'b0100;
        #1;
        check("single_in_ready", 32'(br.in_ready), 32'h4);
        tick();
        check("single_valid", 32'(br.out_valid),  32'h1);
        check("single_data",  32'(br.out_data),   32'hA5);
        check("single_sel",   32'(br.out_select), 32'h2);
        br.in_valid = 4'b0000;
        tick();
        check("drain_valid", 32'(br.out_valid), 32'h0);
        check("drain_hold",  32'(br.out_data),  32'hA5);

        // Pointer at 3 wraps past the idle channel to 0, then 1
        br.in_valid = 4'b0011;
        #1;
        check("wrap_ready0", 32'(br.in_ready), 32'h1);
        tick();
        check("wrap_sel0", 32'(br.out_select), 32'h0);
        check("wrap_dat0", 32'(br.out_data),   32'h00);
        check("wrap_ready1", 32'(br.in_ready), 32'h2);
        tick();
        check("wrap_sel1", 32'(br.out_select), 32'h1);
        check("wrap_dat1", 32'(br.out_data),   32'h01);
        br.in_valid = 4'b0000;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_idle_valid", 32'(br.out_valid), 32'h0);

        // Fairness with all channels busy
        br.in_valid = 4'b1111;
        br.in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        #1;
        for (int k = 0; k < 10; k++) begin
            check("fair_ready", 32'(br.in_ready), 32'(1 << (k % 4)));
            tick();
            check("fair_valid", 32'(br.out_valid),  32'h1);
            check("fair_sel",   32'(br.out_select), 32'(k % 4));
            check("fair_data",  32'(br.out_data),   32'(8'h10 + (k % 4)));
        end

        // Backpressure holding 8'h11
        br.out_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("stall_ready", 32'(br.in_ready),  32'h0);
            tick();
            check("stall_valid", 32'(br.out_valid), 32'h1);
            check("stall_data",  32'(br.out_data),  32'h11);
        end
        br.out_ready = 1'b1;
        #1;
        check("unstall_ready", 32'(br.in_ready), 32'h4);
        tick();
        check("unstall_data", 32'(br.out_data),   32'h12);
        check("unstall_sel",  32'(br.out_select), 32'h2);

        // Clear with output full and all channels requesting
        clear = 1'b1;
        #1;
        check("clear_ready", 32'(br.in_ready), 32'h0);
        tick();
        clear = 1'b0;
        check("clear_valid", 32'(br.out_valid),  32'h0);
        check("clear_hold",  32'(br.out_data),   32'h12);
        #1;
        check("clear_ptr0", 32'(br.in_ready), 32'h1);
        tick();
        check("post_clear_data", 32'(br.out_data), 32'h10);

        // Asynchronous reset between edges
        #2;
        reset_n = 1'b0;
        #1;
        check("async_valid", 32'(br.out_valid),  32'h0);
        check("async_data",  32'(br.out_data),   32'h0);
        check("async_sel",   32'(br.out_select), 32'h0);
        check("async_ready", 32'(br.in_ready),   32'h0);
        reset_n = 1'b1;
        #1;
        check("after_rst_ready", 32'(br.in_ready), 32'h1);
        tick();
        check("after_rst_data", 32'(br.out_data),   32'h10);
        check("after_rst_sel",  32'(br.out_select), 32'h0);

        // Fixed priority: channel 1 starves channel 3
        br.in_valid = 4'b0000;
        bf.in_valid = 4'b1010;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("fp_ready", 32'(bf.in_ready), 32'h2);
            tick();
            check("fp_sel",  32'(bf.out_select), 32'h1);
            check("fp_data", 32'(bf.out_data),   32'h21);
        end
        bf.in_valid = 4'b1000;
        #1;
        check("fp_ready3", 32'(bf.in_ready), 32'h8);
        tick();
        check("fp_sel3",  32'(bf.out_select), 32'h3);
        check("fp_data3", 32'(bf.out_data),   32'h23);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N:1 streaming multiplexer with valid/ready handshake on every channel.
- Arbitration is round-robin or fixed-priority, selected by parameter.
- Output is a single registered stage (1-cycle latency, full throughput).
- Generalises the combinational select-mux cells into a sequential arbiter. Used where several producers share one consumer, e.g. the fetch/load/store requests to the memory port.

Parameters:
- BITS, 8, data width per channel (>=1).
- CHANNELS, 4, number of input channels (2..16).
- FIXED_PRIORITY, 0; 0 = round-robin, 1 = fixed priority (lowest index wins).
- SEL_BITS, derived, $clog2(CHANNELS). Localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous flush of the output stage and the round-robin pointer
- in_valid  input  CHANNELS  per-channel valid
- in_data  input  CHANNELS*BITS  flattened data; channel i occupies [i*BITS +: BITS]
- in_ready  output  CHANNELS  per-channel ready; combinational
- out_valid  output  1  output stage holds data
- out_ready  input  1  consumer accepts
- out_data  output  BITS  registered data
- out_select  output  SEL_BITS  index of the channel that supplied out_data

Behaviour:
- Reset (reset_n low, asynchronous): out_valid=0, out_data=0, out_select=0, rr_ptr=0.
- can_load = !out_valid || out_ready.
- Grant (combinational, from in_valid and rr_ptr):
  - Round-robin: first valid channel searching rr_ptr, rr_ptr+1, ... wrapping modulo CHANNELS.
  - Fixed priority: lowest-index valid channel; rr_ptr is unused and stays at 0.
- in_ready[i] = can_load && !clear && (any in_valid) && grant==i. At most one bit is high; all bits are 0 when no channel is valid.
- Transfer on a channel = in_valid[i] && in_ready[i]. On the next edge:
  - out_data = data of channel i, out_select = i, out_valid = 1.
  - Round-robin only: rr_ptr = (i+1) mod CHANNELS, wrapping from CHANNELS-1 to 0.
- Drain without refill (out_valid && out_ready, no transfer): out_valid goes to 0. out_data and out_select hold their last values.
- Stall (out_valid && !out_ready): out_data and out_select hold. All in_ready bits are 0.
- Simultaneous drain and load: a new word loads in the same cycle the old one drains. No bubble, so throughput is 1 word/cycle.
- Latency: input handshake at edge N gives out_valid at edge N+1.
- rr_ptr changes only on a transfer. Idle cycles never advance it.
- clear (synchronous, highest priority after reset):
  - Next edge: out_valid=0, rr_ptr=0. out_data and out_select hold.
  - No input transfer occurs in a clear cycle.
- Grant stability: a stalled requester sees in_ready=0. The grant is re-evaluated every cycle, and inputs may deassert valid before a handshake.
- Fairness (round-robin): with all channels continuously valid and out_ready=1, grants cycle 0,1,...,N-1,0. Every requester is served within CHANNELS transfers.
- Reset mid-operation: the word in the output stage is discarded. No output is X after reset.

Test Plan (BITS=8, CHANNELS=4 unless stated):
1. Reset and single channel: reset_n low with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0. Release, then in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=A5, out_select=2.
2. Round-robin fairness: in_valid=4'b1111 held, ch i data=8'h10+i, out_ready=1 for 8 cycles -> out_select sequence 0,1,2,3,0,1,2,3 with data 10,11,12,13,10,...; one word every cycle.
3. Backpressure: out_valid=1 holding 8'h11 and out_ready=0 for 3 cycles -> in_ready=0, out_data stays 11. out_ready=1 -> 11 accepted, next granted word loads in the same cycle.
4. Pointer wrap and skip: rr_ptr=3, in_valid=4'b0011 -> grant 0, then rr_ptr=1 -> next grant 1 -> rr_ptr=2.
5. Fixed priority (FIXED_PRIORITY=1): in_valid=4'b1010 held -> out_select always 1; channel 3 starves until ch1 deasserts.
6. Clear and async reset: clear=1 while out_valid=1 and in_valid=4'b1111 -> in_ready=0; next cycle out_valid=0, rr_ptr=0. Pulse reset_n mid-stream between edges -> out_valid=0 immediately.
